gen1_tx_os_scheduler: RTL and testbench

- Gen1 transmit-side scheduler that sits directly upstream of the Gen1 scrambler.
- Each cycle it multiplexes link-layer beats (TLP/DLLP symbols), periodic SKP ordered sets, a one-shot EIOS and logical-idle fill into one symbol stream (data/K/valid), so the PHY receives an unbroken symbol stream.
- It enforces packet-boundary-only ordered-set insertion and the SKP interval, at PIPE widths 8/16/32.

---
 rtl/gen1_tx_os_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_gen1_tx_os_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen1_tx_os_scheduler.sv
// gen1_tx_os_scheduler
//   Gen1 transmit-side symbol scheduler feeding the scrambler. Each cycle it
//   picks one of: a link-layer beat, a SKP ordered set, a one-shot EIOS, or
//   logical idle. Ordered sets are only inserted at packet boundaries. The
//   PIPE width can be 8, 16 or 32 bits (N = 1/2/4 symbols per cycle).
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   tx_en_i            transmitter enable from the LTSSM
//   pipe_width_i       PIPE width in bits; N = pipe_width_i>>3 (1/2/4, else 1)
//   link_valid_i/link_ready_o/link_data_i/link_k_i/link_last_i
//                      link beat handshake; ready is combinational
//   eios_req_i         level request for an EIOS at the next boundary
//   eios_done_o        pulse on the cycle after the last EIOS symbol
//   skp_sent_o         pulse on the cycle a SKP OS starts on data_o
//   data_valid_o, data_o, data_k_o
//                      registered symbol stream; byte 0 = first symbol

// One byte lane: chooses the ordered-set symbol for its slot, the link byte,
// or zero (logical idle / unused lane).
module gen1_tx_os_lane #(
  parameter int LANE = 0
) (
  input  logic       lane_en,
  input  logic       emit_os,
  input  logic       emit_beat,
  input  logic       os_is_skp,
  input  logic [1:0] os_base,
  input  logic [7:0] link_sym,
  input  logic       link_k,
  output logic [7:0] sym,
  output logic       sym_k
);
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] IDL = 8'h7C;

  // Position of this lane's symbol inside the 4-symbol ordered set.
  logic [1:0] os_pos;
  assign os_pos = os_base + 2'(LANE);

  always_comb begin
    sym   = '0;
    sym_k = 1'b0;
    if (lane_en && emit_os) begin
      sym   = (os_pos == 2'd0) ? COM : (os_is_skp ? SKP : IDL);
      sym_k = 1'b1;
    end else if (lane_en && emit_beat) begin
      sym   = link_sym;
      sym_k = link_k;
    end
  end
endmodule

module gen1_tx_os_scheduler #(
  parameter int SKP_INTERVAL    = 1180,
  parameter int MAX_SKP_PENDING = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tx_en_i,
  input  logic [5:0]  pipe_width_i,
  input  logic        link_valid_i,
  output logic        link_ready_o,
  input  logic [31:0] link_data_i,
  input  logic [3:0]  link_k_i,
  input  logic        link_last_i,
  input  logic        eios_req_i,
  output logic        eios_done_o,
  output logic        skp_sent_o,
  output logic        data_valid_o,
  output logic [31:0] data_o,
  output logic [3:0]  data_k_o
);
  localparam int NUM_LANES = 4;
  localparam int PEND_W    = $clog2(MAX_SKP_PENDING + 1);

  typedef enum logic [1:0] {S_OFF, S_STREAM, S_OS, S_EI} state_t;

  state_t              state_q, state_d;
  logic [11:0]         sym_cnt_q, sym_cnt_d;
  logic [PEND_W-1:0]   skp_pend_q, skp_pend_d;
  logic [1:0]          os_idx_q, os_idx_d;
  logic                os_skp_q, os_skp_d;
  logic                in_pkt_q, in_pkt_d;

  logic [2:0]          nsym;
  logic                boundary, start_eios, start_skp, start_os;
  logic                os_active, os_end, os_skp, accept, cnt_run, cnt_wrap;
  logic [1:0]          os_base;
  logic [2:0]          os_next;
  logic [12:0]         cnt_sum;
  logic                valid_d, done_d;
  logic [NUM_LANES-1:0]            lane_en;
  logic [NUM_LANES-1:0][7:0]       lane_sym;
  logic [NUM_LANES-1:0]            lane_k;

  // Width decode; the low three bits never affect N.
  logic unused_pw_lsbs;
  assign unused_pw_lsbs = ^pipe_width_i[2:0];

  always_comb begin
    case (pipe_width_i[5:3])
      3'd2:    nsym = 3'd2;
      3'd4:    nsym = 3'd4;
      default: nsym = 3'd1;
    endcase
  end

  // Boundary arbitration: EIOS beats SKP beats link traffic.
  assign boundary   = tx_en_i && (state_q == S_STREAM) && !in_pkt_q;
  assign start_eios = boundary && eios_req_i;
  assign start_skp  = boundary && !eios_req_i && (skp_pend_q != '0);
  assign start_os   = start_eios || start_skp;

  // The boundary cycle that starts an OS already emits its first N symbols,
  // so the OS follows the previous packet without an idle gap. S_OS only
  // covers the remaining symbols at narrow widths.
  assign os_active = start_os || (tx_en_i && (state_q == S_OS));
  assign os_base   = (state_q == S_OS) ? os_idx_q : 2'd0;
  assign os_skp    = (state_q == S_OS) ? os_skp_q : start_skp;
  assign os_next   = {1'b0, os_base} + nsym;
  assign os_end    = os_active && (os_next >= 3'd4);

  assign link_ready_o = !rst_i && tx_en_i && (state_q == S_STREAM) && !start_os;
  assign accept       = link_ready_o && link_valid_i;

  // SKP interval counter runs in every symbol-producing cycle, OS included.
  assign cnt_run  = tx_en_i && ((state_q == S_STREAM) || (state_q == S_OS));
  assign cnt_sum  = {1'b0, sym_cnt_q} + {10'b0, nsym};
  assign cnt_wrap = cnt_run && (cnt_sum >= 13'(SKP_INTERVAL));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_OFF;
      sym_cnt_q    <= '0;
      skp_pend_q   <= '0;
      os_idx_q     <= '0;
      os_skp_q     <= 1'b0;
      in_pkt_q     <= 1'b0;
      data_valid_o <= 1'b0;
      data_o       <= '0;
      data_k_o     <= '0;
      eios_done_o  <= 1'b0;
      skp_sent_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      skp_pend_q   <= skp_pend_d;
      os_idx_q     <= os_idx_d;
      os_skp_q     <= os_skp_d;
      in_pkt_q     <= in_pkt_d;
      data_valid_o <= valid_d;
      data_o       <= lane_sym;
      data_k_o     <= lane_k;
      eios_done_o  <= done_d;
      skp_sent_o   <= start_skp;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    if (!tx_en_i)
      state_d = S_OFF;
    else if (os_active)
      state_d = !os_end ? S_OS : (os_skp ? S_STREAM : S_EI);
    else if (state_q == S_OFF)
      state_d = S_STREAM;

    if (!cnt_run)
      sym_cnt_d = '0;
    else if (cnt_wrap)
      sym_cnt_d = 12'(cnt_sum - 13'(SKP_INTERVAL));
    else
      sym_cnt_d = cnt_sum[11:0];

    // A simultaneous increment and SKP start cancel out.
    skp_pend_d = skp_pend_q;
    if (!cnt_run)
      skp_pend_d = '0;
    else if (cnt_wrap && !start_skp && (skp_pend_q != PEND_W'(MAX_SKP_PENDING)))
      skp_pend_d = skp_pend_q + 1'b1;
    else if (!cnt_wrap && start_skp)
      skp_pend_d = skp_pend_q - 1'b1;

    in_pkt_d = in_pkt_q;
    if (!tx_en_i)
      in_pkt_d = 1'b0;
    else if (accept)
      in_pkt_d = !link_last_i;

    os_idx_d = (os_active && !os_end) ? os_next[1:0] : 2'd0;
    os_skp_d = os_active ? os_skp : 1'b0;
  end

  // Output logic
  always_comb begin
    valid_d = cnt_run;
    // data_valid_o is still high only on the first EI cycle (it carried the
    // last EIOS symbol), which is exactly when the done pulse is due.
    done_d  = tx_en_i && (state_q == S_EI) && data_valid_o;
  end

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    assign lane_en[j] = (3'(j) < nsym);
    gen1_tx_os_lane #(.LANE(j)) u_lane (
      .lane_en   (lane_en[j]),
      .emit_os   (os_active),
      .emit_beat (accept),
      .os_is_skp (os_skp),
      .os_base   (os_base),
      .link_sym  (link_data_i[8*j +: 8]),
      .link_k    (link_k_i[j]),
      .sym       (lane_sym[j]),
      .sym_k     (lane_k[j])
    );
  end
endmodule

// File: tb/tb_gen1_tx_os_scheduler.sv
module tb_gen1_tx_os_scheduler;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, lv, ll, er;
  logic [5:0]  pw;
  logic [31:0] ld;
  logic [3:0]  lk;
  logic        link_ready, eios_done, skp_sent, dvalid;
  logic [31:0] dout;
  logic [3:0]  dk;

  gen1_tx_os_scheduler dut (
    .clk_i(clk), .rst_i(rst), .tx_en_i(en), .pipe_width_i(pw),
    .link_valid_i(lv), .link_ready_o(link_ready), .link_data_i(ld),
    .link_k_i(lk), .link_last_i(ll), .eios_req_i(er),
    .eios_done_o(eios_done), .skp_sent_o(skp_sent),
    .data_valid_o(dvalid), .data_o(dout), .data_k_o(dk)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a symbol queue for ordered sets plus owed-SKP bookkeeping.
  bit          m_on, m_ei, m_ei_fresh, m_in_pkt, m_os_eios;
  int          m_cnt, m_pend;
  logic [8:0]  m_osq[$];
  bit          e_ready, e_valid, e_skp, e_done;
  logic [31:0] e_data;
  logic [3:0]  e_k;

  task automatic model_step();
    int n;
    bit inc;
    logic [8:0] s;
    n = int'(pw) / 8;
    if (n != 1 && n != 2 && n != 4) n = 1;
    e_ready = 0; e_valid = 0; e_skp = 0; e_done = 0; e_data = '0; e_k = '0;
    if (rst || !en) begin
      m_on = 0; m_ei = 0; m_ei_fresh = 0; m_in_pkt = 0; m_cnt = 0; m_pend = 0;
      m_osq.delete();
      return;
    end
    if (m_ei) begin
      e_done = m_ei_fresh;
      m_ei_fresh = 0;
      return;
    end
    if (!m_on) begin
      m_on = 1;
      return;
    end
    e_valid = 1;
    inc = 0;
    m_cnt += n;
    if (m_cnt >= 1180) begin m_cnt -= 1180; inc = 1; end
    if (m_osq.size() == 0 && !m_in_pkt) begin
      if (er) begin
        m_osq = '{9'h1BC, 9'h17C, 9'h17C, 9'h17C};
        m_os_eios = 1;
      end else if (m_pend > 0) begin
        m_osq = '{9'h1BC, 9'h11C, 9'h11C, 9'h11C};
        m_os_eios = 0;
        m_pend--;
        e_skp = 1;
      end
    end
    if (m_osq.size() > 0) begin
      for (int j = 0; j < n; j++) begin
        s = m_osq.pop_front();
        e_data[8*j +: 8] = s[7:0];
        e_k[j] = s[8];
      end
      if (m_osq.size() == 0 && m_os_eios) begin
        m_on = 0; m_ei = 1; m_ei_fresh = 1;
      end
    end else begin
      e_ready = 1;
      if (lv) begin
        for (int j = 0; j < n; j++) begin
          e_data[8*j +: 8] = ld[8*j +: 8];
          e_k[j] = lk[j];
        end
        m_in_pkt = !ll;
      end
    end
    if (inc && m_pend < 3) m_pend++;
  endtask

  // Output log, one entry per clock.
  logic [31:0] lg_data[$];
  logic [3:0]  lg_k[$];
  bit          lg_skp[$], lg_valid[$], lg_done[$];
  bit          acc, ready_seen;

  task automatic tick();
    #1;
    ready_seen = link_ready;
    acc = lv && link_ready;
    model_step();
    chk("link_ready", link_ready, e_ready);
    @(posedge clk);
    #1;
    chk("outputs{valid,k,data,skp,done}",
        {dvalid, dk, dout, skp_sent, eios_done},
        {e_valid, e_k, e_data, e_skp, e_done});
    lg_data.push_back(dout); lg_k.push_back(dk); lg_skp.push_back(skp_sent);
    lg_valid.push_back(dvalid); lg_done.push_back(eios_done);
  endtask

  task automatic idle_link();
    lv = 0; ld = '0; lk = '0; ll = 0; er = 0;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; idle_link();
    tick();
    rst = 0;
  endtask

  function automatic int find_skp(input int from);
    for (int i = from; i < lg_skp.size(); i++)
      if (lg_skp[i]) return i;
    return -1;
  endfunction

  function automatic int count_skp(input int from, input int to);
    int c = 0;
    for (int i = from; i < to && i < lg_skp.size(); i++)
      if (lg_skp[i]) c++;
    return c;
  endfunction

  typedef struct {
    bit          rst, en, lv;
    logic [31:0] ld;
    logic [3:0]  lk;
    bit          ll, er;
    bit          x_ready, x_valid;
    logic [31:0] x_data;
    logic [3:0]  x_k;
    bit          x_done;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    bit          last;
  } beat_t;

  initial begin
    vec_t  tbl[13];
    beat_t src[$];
    logic [5:0] widths[6];
    int base, i1, i2, li, guard;

    rst = 1; en = 0; pw = 6'd32; idle_link();

    // Width 32: toggling valid inside a packet, EIOS requested mid-packet.
    tbl[0]  = '{1, 0, 0, 32'h0,        4'h0, 0, 0,  0, 0, 32'h0,        4'h0, 0};
    tbl[1]  = '{0, 1, 0, 32'h0,        4'h0, 0, 0,  0, 0, 32'h0,        4'h0, 0};
    tbl[2]  = '{0, 1, 1, 32'hA1B2C3D4, 4'h1, 0, 0,  1, 1, 32'hA1B2C3D4, 4'h1, 0};
    tbl[3]  = '{0, 1, 0, 32'h0,        4'h0, 0, 0,  1, 1, 32'h0,        4'h0, 0};
    tbl[4]  = '{0, 1, 1, 32'h11223344, 4'h0, 0, 0,  1, 1, 32'h11223344, 4'h0, 0};
    tbl[5]  = '{0, 1, 0, 32'h0,        4'h0, 0, 1,  1, 1, 32'h0,        4'h0, 0};
    tbl[6]  = '{0, 1, 1, 32'h55667788, 4'h8, 1, 1,  1, 1, 32'h55667788, 4'h8, 0};
    tbl[7]  = '{0, 1, 0, 32'h0,        4'h0, 0, 1,  0, 1, 32'h7C7C7CBC, 4'hF, 0};
    tbl[8]  = '{0, 1, 0, 32'h0,        4'h0, 0, 0,  0, 0, 32'h0,        4'h0, 1};
    tbl[9]  = '{0, 1, 0, 32'h0,        4'h0, 0, 0,  0, 0, 32'h0,        4'h0, 0};
    tbl[10] = '{0, 0, 0, 32'h0,        4'h0, 0, 0,  0, 0, 32'h0,        4'h0, 0};
    tbl[11] = '{0, 1, 0, 32'h0,        4'h0, 0, 0,  0, 0, 32'h0,        4'h0, 0};
    tbl[12] = '{0, 1, 1, 32'hCAFEF00D, 4'h0, 1, 0,  1, 1, 32'hCAFEF00D, 4'h0, 0};
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; lv = tbl[i].lv; ld = tbl[i].ld;
      lk = tbl[i].lk; ll = tbl[i].ll; er = tbl[i].er;
      tick();
      chk($sformatf("tbl%0d_ready", i), ready_seen, tbl[i].x_ready);
      chk($sformatf("tbl%0d_out", i), {dvalid, dk, dout, eios_done},
          {tbl[i].x_valid, tbl[i].x_k, tbl[i].x_data, tbl[i].x_done});
    end

    // Width 32 idle stream: SKP every 295 cycles.
    do_reset();
    base = lg_skp.size();
    pw = 6'd32; en = 1;
    repeat (700) tick();
    i1 = find_skp(base);
    i2 = (i1 < 0) ? -1 : find_skp(i1 + 1);
    chk("w32_first_skp_offset", i1 - base, 296);
    chk("w32_skp_period", i2 - i1, 295);
    if (i1 >= 0) chk("w32_skp_sym", {lg_k[i1], lg_data[i1]}, {4'hF, 32'h1C1C1CBC});
    if (i1 > 0) chk("w32_idle_before_skp", {lg_valid[i1-1], lg_k[i1-1], lg_data[i1-1]}, {1'b1, 4'h0, 32'h0});

    // Width 8: SKP spread over 4 cycles, next one 1180 cycles later.
    do_reset();
    base = lg_skp.size();
    pw = 6'd8; en = 1;
    repeat (2400) tick();
    i1 = find_skp(base);
    i2 = (i1 < 0) ? -1 : find_skp(i1 + 1);
    chk("w8_first_skp_offset", i1 - base, 1181);
    chk("w8_skp_period", i2 - i1, 1180);
    if (i1 >= 0)
      for (int s = 0; s < 4; s++)
        chk($sformatf("w8_skp_sym%0d", s), {lg_k[i1+s], lg_data[i1+s]},
            {4'h1, 24'h0, (s == 0) ? 8'hBC : 8'h1C});

    // Width 16: long packet with two SKPs owed, sent back to back afterwards.
    do_reset();
    pw = 6'd16; en = 1;
    tick();
    base = lg_skp.size();
    li = -1;
    for (int b = 0; b < 400; b++) begin
      lv = 0; tick(); tick();
      lv = 1; ld = {16'h0, 16'(b + 16'h100)}; lk = 4'h0; ll = (b == 399);
      tick();
      chk($sformatf("w16_beat%0d_acc", b), acc, 1'b1);
      if (b == 399) li = lg_skp.size() - 1;
    end
    chk("w16_no_skp_in_pkt", count_skp(base, li + 1), 0);
    lv = 1; ld = 32'h0000BEEF; ll = 1;
    guard = 0;
    do begin tick(); guard++; end while (!acc && guard < 10);
    chk("w16_next_pkt_accepted", acc, 1'b1);
    lv = 0; ll = 0;
    for (int s = 0; s < 4; s++)
      chk($sformatf("w16_os_sym%0d", s), {lg_skp[li+1+s], lg_k[li+1+s], lg_data[li+1+s]},
          {(s % 2) == 0, 4'h3, 16'h0, (s % 2 == 0) ? 16'h1CBC : 16'h1C1C});
    chk("w16_next_beat", {lg_k[li+5], lg_data[li+5]}, {4'h0, 32'h0000BEEF});

    // Width 8: EIOS and an owed SKP at the same boundary -> EIOS only.
    do_reset();
    pw = 6'd8; en = 1;
    tick();
    base = lg_skp.size();
    lv = 1; ld = 32'h55; ll = 0; tick();
    lv = 0;
    repeat (1185) tick();
    lv = 1; ld = 32'h66; ll = 1; er = 1; tick();
    li = lg_skp.size() - 1;
    lv = 0; ll = 0;
    repeat (4) tick();
    er = 0;
    repeat (3) tick();
    for (int s = 0; s < 4; s++)
      chk($sformatf("eios_sym%0d", s), {lg_k[li+1+s], lg_data[li+1+s]},
          {4'h1, 24'h0, (s == 0) ? 8'hBC : 8'h7C});
    chk("eios_done_pulse", {lg_done[li+5], lg_valid[li+5], lg_done[li+6]}, 3'b100);
    chk("eios_no_skp", count_skp(base, lg_skp.size()), 0);
    en = 0; tick();

    // Width 8: reset on the 2nd symbol of a SKP OS.
    do_reset();
    pw = 6'd8; en = 1;
    guard = 0;
    do begin tick(); guard++; end while (!skp_sent && guard < 1300);
    chk("rst_mid_os_found_skp", skp_sent, 1'b1);
    rst = 1; tick();
    chk("rst_mid_os_outputs", {dvalid, dk, dout, skp_sent, eios_done, link_ready}, 39'h0);
    rst = 0; tick();
    chk("rst_mid_os_off", dvalid, 1'b0);
    tick();
    chk("rst_mid_os_restart", {dvalid, dk, dout}, {1'b1, 4'h0, 32'h0});

    // Randomized traffic against the model.
    widths = '{6'd8, 6'd16, 6'd32, 6'd0, 6'd40, 6'd24};
    do_reset();
    for (int seg = 0; seg < 8; seg++) begin
      en = 0; idle_link(); tick(); tick();
      pw = widths[$urandom_range(0, 5)];
      for (int c = 0; c < 700; c++) begin
        if (src.size() == 0) begin
          int len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) begin
            beat_t bt;
            bt.d = $urandom; bt.k = 4'($urandom); bt.last = (b == len - 1);
            src.push_back(bt);
          end
        end
        lv = ($urandom_range(0, 3) != 0);
        ld = src[0].d; lk = src[0].k; ll = src[0].last;
        er = er ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 299) == 0);
        rst = ($urandom_range(0, 599) == 0);
        en = ($urandom_range(0, 399) != 0);
        tick();
        if (acc) void'(src.pop_front());
      end
      rst = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
